lru_assoc_table: RTL and testbench

//  Fully-associative key->value table (e.g. PC->target), DEPTH entries, true-LRU replacement.

---
 rtl/lru_assoc_table.sv | 181 ++++++++++++++++++
 tb/tb_lru_assoc_table.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lru_assoc_table.sv
// Fully-associative key->value table with true-LRU replacement, valid bits,
// MRU promotion on touched read hits, invalidate, flush, occupancy and eviction report.
module lru_assoc_table #(
    parameter int unsigned KEY_WIDTH = 16,
    parameter int unsigned VAL_WIDTH = 16,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      write,
    input  logic [KEY_WIDTH-1:0]      write_key,
    input  logic [VAL_WIDTH-1:0]      write_val,
    input  logic                      invalidate,
    input  logic [KEY_WIDTH-1:0]      inv_key,
    input  logic                      flush,
    input  logic [KEY_WIDTH-1:0]      read_key,
    input  logic                      read_touch,
    output logic [VAL_WIDTH-1:0]      read_val,
    output logic                      read_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      evict_valid,
    output logic [KEY_WIDTH-1:0]      evict_key,
    output logic [VAL_WIDTH-1:0]      evict_val
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [KEY_WIDTH-1:0] key_q [DEPTH];
    logic [KEY_WIDTH-1:0] key_d [DEPTH];
    logic [VAL_WIDTH-1:0] val_q [DEPTH];
    logic [VAL_WIDTH-1:0] val_d [DEPTH];
    logic [AW-1:0]        age_q [DEPTH];
    logic [AW-1:0]        age_d [DEPTH];
    logic [CW-1:0]        count_q, count_d;
    logic                 evict_valid_q, evict_valid_d;
    logic [KEY_WIDTH-1:0] evict_key_q, evict_key_d;
    logic [VAL_WIDTH-1:0] evict_val_q, evict_val_d;

    logic          rd_hit, wr_hit, inv_hit, free_any;
    logic [AW-1:0] rd_idx, wr_idx, inv_idx, free_idx, lru_idx;
    logic          promote, demote;
    logic [AW-1:0] tgt;

    // Match search over registered state only; valid bits guarantee a unique hit.
    always_comb begin
        rd_hit   = 1'b0;
        wr_hit   = 1'b0;
        inv_hit  = 1'b0;
        free_any = 1'b0;
        rd_idx   = '0;
        wr_idx   = '0;
        inv_idx  = '0;
        free_idx = '0;
        lru_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && key_q[i] == read_key) begin
                rd_hit = 1'b1;
                rd_idx = AW'(i);
            end
            if (valid_q[i] && key_q[i] == write_key) begin
                wr_hit = 1'b1;
                wr_idx = AW'(i);
            end
            if (valid_q[i] && key_q[i] == inv_key) begin
                inv_hit = 1'b1;
                inv_idx = AW'(i);
            end
            if (!valid_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = AW'(i);
            end
            if (age_q[i] == AW'(DEPTH - 1)) begin
                lru_idx = AW'(i);
            end
        end
    end

    assign read_valid = rd_hit;
    assign read_val   = rd_hit ? val_q[rd_idx] : '0;

    // One operation per cycle: flush > write > invalidate > touch.
    always_comb begin
        valid_d       = valid_q;
        key_d         = key_q;
        val_d         = val_q;
        age_d         = age_q;
        count_d       = count_q;
        evict_valid_d = 1'b0;
        evict_key_d   = evict_key_q;
        evict_val_d   = evict_val_q;
        promote       = 1'b0;
        demote        = 1'b0;
        tgt           = '0;

        if (flush) begin
            valid_d = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = AW'(i);
            end
        end else if (write) begin
            promote = 1'b1;
            if (wr_hit) begin
                tgt        = wr_idx;
                val_d[tgt] = write_val;
            end else begin
                if (free_any) begin
                    tgt     = free_idx;
                    count_d = count_q + CW'(1);
                end else begin
                    tgt           = lru_idx;
                    evict_valid_d = 1'b1;
                    evict_key_d   = key_q[tgt];
                    evict_val_d   = val_q[tgt];
                end
                valid_d[tgt] = 1'b1;
                key_d[tgt]   = write_key;
                val_d[tgt]   = write_val;
            end
        end else if (invalidate && inv_hit) begin
            demote       = 1'b1;
            tgt          = inv_idx;
            valid_d[tgt] = 1'b0;
            count_d      = count_q - CW'(1);
        end else if (read_touch && rd_hit) begin
            promote = 1'b1;
            tgt     = rd_idx;
        end

        // Age updates keep the ages a permutation of 0..DEPTH-1.
        if (promote) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age_q[i] < age_q[tgt]) begin
                    age_d[i] = age_q[i] + AW'(1);
                end
            end
            age_d[tgt] = '0;
        end else if (demote) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (age_q[i] > age_q[tgt]) begin
                    age_d[i] = age_q[i] - AW'(1);
                end
            end
            age_d[tgt] = AW'(DEPTH - 1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            count_q       <= '0;
            evict_valid_q <= 1'b0;
            evict_key_q   <= '0;
            evict_val_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= AW'(i);
            end
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            evict_valid_q <= evict_valid_d;
            evict_key_q   <= evict_key_d;
            evict_val_q   <= evict_val_d;
            age_q         <= age_d;
        end
    end

    // Payload storage carries no reset; valid bits qualify it.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        val_q <= val_d;
    end

    assign count       = count_q;
    assign evict_valid = evict_valid_q;
    assign evict_key   = evict_key_q;
    assign evict_val   = evict_val_q;

endmodule

// File: tb/tb_lru_assoc_table.sv
// Directed self-checking bench for lru_assoc_table at DEPTH=4, 16-bit keys/values.
module tb_lru_assoc_table;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        write;
    logic [15:0] write_key, write_val;
    logic        invalidate;
    logic [15:0] inv_key;
    logic        flush;
    logic [15:0] read_key;
    logic        read_touch;
    logic [15:0] read_val;
    logic        read_valid;
    logic [2:0]  count;
    logic        evict_valid;
    logic [15:0] evict_key, evict_val;

    int checks   = 0;
    int failures = 0;

    lru_assoc_table #(.KEY_WIDTH(16), .VAL_WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .write(write), .write_key(write_key), .write_val(write_val),
        .invalidate(invalidate), .inv_key(inv_key), .flush(flush),
        .read_key(read_key), .read_touch(read_touch),
        .read_val(read_val), .read_valid(read_valid), .count(count),
        .evict_valid(evict_valid), .evict_key(evict_key), .evict_val(evict_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] k, input logic [15:0] v);
        write = 1'b1; write_key = k; write_val = v;
        tick();
        write = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [15:0] k, input logic hit, input logic [15:0] v);
        read_key = k;
        #1;
        chk({tag, "_valid"}, 32'(read_valid), 32'(hit));
        chk({tag, "_val"}, 32'(read_val), 32'(v));
    endtask

    initial begin
        reset_n = 1'b0; write = 1'b0; write_key = '0; write_val = '0;
        invalidate = 1'b0; inv_key = '0; flush = 1'b0;
        read_key = '0; read_touch = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // 1: reset state, no stale hit on key 0
        lookup("rst_read0", 16'h0000, 1'b0, 16'h0000);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_evict", 32'(evict_valid), 32'd0);

        // 2: fill the table; ages end as 0x10 LRU ... 0x40 MRU
        do_write(16'h0010, 16'h00A0);
        chk("fill1_count", 32'(count), 32'd1);
        do_write(16'h0020, 16'h00B0);
        do_write(16'h0030, 16'h00C0);
        do_write(16'h0040, 16'h00D0);
        chk("fill4_count", 32'(count), 32'd4);
        chk("fill_noevict", 32'(evict_valid), 32'd0);
        lookup("rd20", 16'h0020, 1'b1, 16'h00B0);

        // 3: touch 0x10 makes 0x20 the LRU victim
        read_key = 16'h0010; read_touch = 1'b1;
        tick();
        read_touch = 1'b0;
        do_write(16'h0050, 16'h00E0);
        chk("ev_valid", 32'(evict_valid), 32'd1);
        chk("ev_key", 32'(evict_key), 32'h0020);
        chk("ev_val", 32'(evict_val), 32'h00B0);
        chk("ev_count", 32'(count), 32'd4);
        tick();
        chk("ev_pulse_end", 32'(evict_valid), 32'd0);
        lookup("rd20_gone", 16'h0020, 1'b0, 16'h0000);
        lookup("rd10_kept", 16'h0010, 1'b1, 16'h00A0);
        lookup("rd50_new", 16'h0050, 1'b1, 16'h00E0);

        // 4: update existing key
        do_write(16'h0030, 16'h0033);
        chk("upd_count", 32'(count), 32'd4);
        chk("upd_noevict", 32'(evict_valid), 32'd0);
        lookup("rd30_upd", 16'h0030, 1'b1, 16'h0033);

        // 5: invalidate frees a slot, refill without eviction
        invalidate = 1'b1; inv_key = 16'h0040;
        tick();
        invalidate = 1'b0;
        chk("inv_count", 32'(count), 32'd3);
        lookup("rd40_inv", 16'h0040, 1'b0, 16'h0000);
        invalidate = 1'b1; inv_key = 16'h0777;
        tick();
        invalidate = 1'b0;
        chk("inv_miss_count", 32'(count), 32'd3);
        do_write(16'h0060, 16'h00F0);
        chk("refill_count", 32'(count), 32'd4);
        chk("refill_noevict", 32'(evict_valid), 32'd0);
        lookup("rd60", 16'h0060, 1'b1, 16'h00F0);
        // write beats invalidate in the same cycle
        invalidate = 1'b1; inv_key = 16'h0050;
        do_write(16'h0030, 16'h003A);
        invalidate = 1'b0;
        chk("prio_count", 32'(count), 32'd4);
        lookup("prio_rd50", 16'h0050, 1'b1, 16'h00E0);
        lookup("prio_rd30", 16'h0030, 1'b1, 16'h003A);

        // 6: flush beats write
        flush = 1'b1;
        do_write(16'h0080, 16'h0088);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        lookup("flush_rd10", 16'h0010, 1'b0, 16'h0000);
        lookup("flush_rd80", 16'h0080, 1'b0, 16'h0000);
        do_write(16'h0090, 16'h0099);
        chk("pf_count", 32'(count), 32'd1);
        lookup("pf_rd90", 16'h0090, 1'b1, 16'h0099);
        // async reset mid-write
        write = 1'b1; write_key = 16'h00A0; write_val = 16'h00AA;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        lookup("arst_rd90", 16'h0090, 1'b0, 16'h0000);
        tick();
        write = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        chk("arst_after_count", 32'(count), 32'd0);
        lookup("arst_rdA0", 16'h00A0, 1'b0, 16'h0000);
        do_write(16'h00B0, 16'h00BB);
        chk("post_count", 32'(count), 32'd1);
        lookup("post_rdB0", 16'h00B0, 1'b1, 16'h00BB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
